subtractor_12bit_seq: RTL
=========================

Name: subtractor_12bit_seq

Overview:
Multi-cycle two's-complement subtractor: result = input1 - input2, processed CHUNK bits per clock as a ripple-borrow chain.
- Inverse operation of the combinational 12-bit ripple adder used in the PE accumulate path.
- Feeds the TPU's difference and offset-removal datapath, such as zero-point subtraction before MAC.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- N, 12, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per BUSY cycle; K = N/CHUNK cycles per operation (default K = 3).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- input1  input  N  minuend, unsigned or two's complement.
- input2  input  N  subtrahend.
- out_valid  output  1  result, borrow_out and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  N  (input1 - input2) mod 2^N.
- borrow_out  output  1  1 iff input1 < input2 as unsigned values.
- overflow  output  1  signed overflow: operand signs differ and the result sign differs from input1's sign.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE. It clears result, borrow_out, overflow, out_valid, the chunk index and the internal borrow to 0. in_ready is 1 in IDLE.
- Reset mid-operation: the operation is discarded and no out_valid is produced. After release the block is in IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid = 1, register input1 and input2, clear the borrow and the index, then go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each edge computes slice [idx*CHUNK +: CHUNK] = a_slice - b_slice - borrow.
  - That slice is written into the result register; the chunk's borrow-out is stored and idx increments.
  - On the edge that processes idx = K-1:
    - borrow_out = the final borrow.
    - overflow = (a[N-1] != b[N-1]) && (res[N-1] != a[N-1]).
    - Go to DONE.
- DONE:
  - out_valid = 1; result, borrow_out and overflow are held stable while out_ready = 0.
  - On an edge with out_ready = 1, go to IDLE.
  - in_ready stays 0 in DONE; no same-cycle re-accept.
- Latency: out_valid rises exactly K edges after the accepting edge (3 for the defaults). Minimum issue interval is K+2 cycles.
- Operands are sampled only at the accepting edge; later changes on input1/input2 are ignored.
- in_valid during BUSY or DONE is ignored and not queued.
- result contents are not defined as valid during BUSY; only out_valid qualifies them.
- Arithmetic:
  - Pure modular subtraction; no saturation.
  - Width-safe: the borrow chain never extends beyond N bits.

Decomposition:
- Package subtractor_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - default N and CHUNK localparams;
  - an index width constant = $clog2(N/CHUNK), minimum 1.
- Sub-module chunk_subtractor:
  - combinational, CHUNK-bit ripple-borrow subtractor with inputs a, b, bin and outputs diff, bout;
  - built from per-bit full-subtractor cells;
  - instantiated once and reused each BUSY cycle.

Test Plan:
- Reset then 100 - 37 with out_ready = 1 -> out_valid high 3 cycles after accept; result = 63 (0x03F), borrow_out = 0, overflow = 0; back to IDLE next cycle.
- 0x000 - 0x001 -> result = 0xFFF, borrow_out = 1, overflow = 0.
- 0x800 - 0x001 (signed -2048 - 1) -> result = 0x7FF, borrow_out = 0, overflow = 1; also 0x7FF - 0xFFF -> result = 0x800, overflow = 1, borrow_out = 1.
- Backpressure: hold out_ready = 0 for 5 cycles on 0xABC - 0x123 -> result = 0x999 held stable with out_valid high; in_ready = 0 throughout; released on the out_ready edge.
- in_valid pulsed with new operands during BUSY, and input1/input2 changed after accept -> first result unaffected (0x500 - 0x0FF = 0x401); second request accepted only after returning to IDLE.
- rst_n asserted asynchronously mid-BUSY (between edges) -> outputs and out_valid go to 0 immediately; no stale result after release; next op 0x00A - 0x003 = 0x007.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked subtractor.
package subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int N_DEFAULT     = 12;
   localparam int CHUNK_DEFAULT = 4;

   // Chunk index counter width; a single-chunk configuration still needs one bit.
   function automatic int idx_width(input int n, input int chunk);
      int w;
      w = $clog2(n / chunk);
      return (w < 1) ? 1 : w;
   endfunction

   localparam int IDX_W_DEFAULT = idx_width(N_DEFAULT, CHUNK_DEFAULT);

endpackage

// File: rtl/subtractor_12bit_seq_chunk_subtractor.sv
// Combinational CHUNK-bit ripple-borrow subtractor built from full-subtractor cells.
module chunk_subtractor #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bin,
   output logic [CHUNK-1:0] diff,
   output logic             bout
);

   logic [CHUNK:0] borrow_chain;

   assign borrow_chain[0] = bin;

   generate
      for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fs
         assign diff[gi]           = a[gi] ^ b[gi] ^ borrow_chain[gi];
         assign borrow_chain[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow_chain[gi]);
      end
   endgenerate

   assign bout = borrow_chain[CHUNK];

endmodule

// File: rtl/subtractor_12bit_seq.sv
// Multi-cycle subtractor: result = input1 - input2, CHUNK bits per clock with a
// registered borrow between chunks and valid/ready handshakes on both sides.
module subtractor_12bit_seq
   import subtractor_pkg::*;
#(
   parameter int N     = N_DEFAULT,
   parameter int CHUNK = CHUNK_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] input1,
   input  logic [N-1:0] input2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         borrow_out,
   output logic         overflow
);

   localparam int K  = N / CHUNK;
   localparam int IW = idx_width(N, CHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

   state_e         state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           borrow_q, borrow_d;
   logic [N-1:0]   result_q, result_d;
   logic           borrow_out_q, borrow_out_d;
   logic           overflow_q, overflow_d;
   logic           out_valid_q, out_valid_d;
   logic           in_ready_q, in_ready_d;

   logic [CHUNK-1:0] a_slice, b_slice, diff_slice;
   logic             chunk_bout;

   assign a_slice = a_q[idx_q*CHUNK +: CHUNK];
   assign b_slice = b_q[idx_q*CHUNK +: CHUNK];

   chunk_subtractor #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a    (a_slice),
      .b    (b_slice),
      .bin  (borrow_q),
      .diff (diff_slice),
      .bout (chunk_bout)
   );

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      idx_d        = idx_q;
      borrow_d     = borrow_q;
      result_d     = result_q;
      borrow_out_d = borrow_out_q;
      overflow_d   = overflow_q;
      out_valid_d  = out_valid_q;
      in_ready_d   = in_ready_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d        = input1;
               b_d        = input2;
               idx_d      = '0;
               borrow_d   = 1'b0;
               in_ready_d = 1'b0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            result_d[idx_q*CHUNK +: CHUNK] = diff_slice;
            borrow_d = chunk_bout;
            if (idx_q == LAST_IDX) begin
               // Overflow looks at the freshly written top slice, not the stale register.
               borrow_out_d = chunk_bout;
               overflow_d   = (a_q[N-1] != b_q[N-1]) && (result_d[N-1] != a_q[N-1]);
               idx_d        = '0;
               out_valid_d  = 1'b1;
               state_d      = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         idx_q        <= '0;
         borrow_q     <= 1'b0;
         result_q     <= '0;
         borrow_out_q <= 1'b0;
         overflow_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         idx_q        <= idx_d;
         borrow_q     <= borrow_d;
         result_q     <= result_d;
         borrow_out_q <= borrow_out_d;
         overflow_q   <= overflow_d;
         out_valid_q  <= out_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign borrow_out = borrow_out_q;
   assign overflow   = overflow_q;

endmodule
